// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
// State encodings, branch codes and hazard priority classes.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_FREEZE = 2'd2,
    ST_REDIR  = 2'd3
  } state_e;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BGEZ = 3'b011;
  localparam logic [2:0] BR_BGTZ = 3'b100;
  localparam logic [2:0] BR_BLEZ = 3'b101;
  localparam logic [2:0] BR_BLTZ = 3'b110;

  typedef enum logic [1:0] {
    PR_FREEZE,
    PR_BUBBLE,
    PR_REDIR,
    PR_RUN
  } prio_e;

  function automatic state_e prio_state(prio_e p);
    unique case (p)
      PR_FREEZE: prio_state = ST_FREEZE;
      PR_BUBBLE: prio_state = ST_BUBBLE;
      PR_REDIR:  prio_state = ST_REDIR;
      default:   prio_state = ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at MAX once reached.
module sat_counter #(
  parameter int             W   = 4,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && q != MAX) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: PC, IF/ID, ID/EX enables.
// Tracks bubble statistics and a sticky stall watchdog.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter bit DELAY_SLOT = 1'b1,
  parameter int CNT_W      = 16,
  parameter int MAX_STALL  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             BranchBubble,
  input  logic             LoadUseBubble,
  input  logic             ex_MdBusy,
  input  logic [2:0]       id_Branch,
  input  logic             id_BranchTaken,
  input  logic             id_Jump,
  output logic             PcWr,
  output logic             IfIdWr,
  output logic             IfIdFlush,
  output logic             IdExWr,
  output logic             IdExFlush,
  output logic             Redirect,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] BubbleCnt,
  output logic             StallErr
);

  localparam int SW = $clog2(MAX_STALL + 2);
  localparam logic [SW-1:0] STALL_SAT = SW'(MAX_STALL + 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(MAX_STALL);

  prio_e         prio;
  state_e        state_q;
  logic          bub;
  logic          tkn;
  logic          stall;
  logic [SW-1:0] stall_run;

  assign bub   = BranchBubble | LoadUseBubble;
  assign tkn   = ((id_Branch != BR_NONE) & id_BranchTaken) | id_Jump;
  assign stall = (prio == PR_FREEZE) || (prio == PR_BUBBLE);

  always_comb begin
    prio      = PR_RUN;
    PcWr      = 1'b0;
    IfIdWr    = 1'b0;
    IfIdFlush = 1'b0;
    IdExWr    = 1'b0;
    IdExFlush = 1'b0;
    Redirect  = 1'b0;
    unique case (1'b1)
      ex_MdBusy:               prio = PR_FREEZE;
      bub && !ex_MdBusy:       prio = PR_BUBBLE;
      tkn && !bub && !ex_MdBusy: prio = PR_REDIR;
      default:                 prio = PR_RUN;
    endcase
    // Reset parks the front end with NOPs in both pipeline registers
    if (!rst_n) begin
      IfIdFlush = 1'b1;
      IdExFlush = 1'b1;
    end else begin
      unique case (prio)
        PR_FREEZE: ;
        PR_BUBBLE: begin
          IdExWr    = 1'b1;
          IdExFlush = 1'b1;
        end
        PR_REDIR: begin
          PcWr      = 1'b1;
          IfIdWr    = 1'b1;
          IdExWr    = 1'b1;
          Redirect  = 1'b1;
          IfIdFlush = !DELAY_SLOT;
        end
        default: begin
          PcWr   = 1'b1;
          IfIdWr = 1'b1;
          IdExWr = 1'b1;
        end
      endcase
    end
  end

  sat_counter #(.W(SW), .MAX(STALL_SAT)) u_stall_run (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall),
    .clr   (!stall),
    .q     (stall_run)
  );

  sat_counter #(.W(CNT_W), .MAX({CNT_W{1'b1}})) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (prio == PR_BUBBLE),
    .clr   (1'b0),
    .q     (BubbleCnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      StallErr <= 1'b0;
    end else begin
      state_q <= prio_state(prio);
      if (stall && stall_run == STALL_LIM) begin
        StallErr <= 1'b1;
      end
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench: two controller variants driven in lockstep.
// A behavioural model queues expected outputs; a monitor checks them.
module tb_pipeline_stall_ctrl;

  localparam int MAXS = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bb = 1'b0;
  logic       lu = 1'b0;
  logic       md = 1'b0;
  logic [2:0] br = 3'b000;
  logic       tk = 1'b0;
  logic       jp = 1'b0;

  logic        pcwr [2];
  logic        ifidwr [2];
  logic        ififl [2];
  logic        idexwr [2];
  logic        idexfl [2];
  logic        redir [2];
  logic [1:0]  st [2];
  logic        serr [2];
  logic [15:0] bc0;
  logic [1:0]  bc1;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.DELAY_SLOT(1'b0), .CNT_W(16), .MAX_STALL(MAXS)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .BranchBubble(bb), .LoadUseBubble(lu), .ex_MdBusy(md),
    .id_Branch(br), .id_BranchTaken(tk), .id_Jump(jp),
    .PcWr(pcwr[0]), .IfIdWr(ifidwr[0]), .IfIdFlush(ififl[0]),
    .IdExWr(idexwr[0]), .IdExFlush(idexfl[0]), .Redirect(redir[0]),
    .State(st[0]), .BubbleCnt(bc0), .StallErr(serr[0])
  );

  pipeline_stall_ctrl #(.DELAY_SLOT(1'b1), .CNT_W(2), .MAX_STALL(MAXS)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .BranchBubble(bb), .LoadUseBubble(lu), .ex_MdBusy(md),
    .id_Branch(br), .id_BranchTaken(tk), .id_Jump(jp),
    .PcWr(pcwr[1]), .IfIdWr(ifidwr[1]), .IfIdFlush(ififl[1]),
    .IdExWr(idexwr[1]), .IdExFlush(idexfl[1]), .Redirect(redir[1]),
    .State(st[1]), .BubbleCnt(bc1), .StallErr(serr[1])
  );

  typedef struct packed {
    logic [1:0][5:0]  ctl;
    logic [1:0][1:0]  st;
    logic [1:0][15:0] bc;
    logic [1:0]       err;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  int m_st [2];
  int m_run [2];
  int m_bc [2];
  bit m_err [2];
  bit ds [2] = '{1'b0, 1'b1};
  int bcmax [2] = '{65535, 3};

  task automatic chk(input string name, input int d,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d t=%0t got %0h expected %0h",
               name, d, $time, act, exp);
    end
  endtask

  // ctl = {PcWr, IfIdWr, IfIdFlush, IdExWr, IdExFlush, Redirect}
  task automatic step(input bit r, input bit b, input bit l, input bit m,
                      input logic [2:0] bcode, input bit t, input bit j);
    exp_t e;
    int   p;
    @(posedge clk);
    #1;
    rst_n = r; bb = b; lu = l; md = m; br = bcode; tk = t; jp = j;
    if (!r) begin
      for (int d = 0; d < 2; d++) begin
        m_st[d] = 0; m_run[d] = 0; m_bc[d] = 0; m_err[d] = 1'b0;
      end
    end
    if (m)                             p = 1;
    else if (b || l)                   p = 2;
    else if ((bcode != 0 && t) || j)   p = 3;
    else                               p = 4;
    for (int d = 0; d < 2; d++) begin
      e.st[d]  = 2'(m_st[d]);
      e.bc[d]  = 16'(m_bc[d]);
      e.err[d] = m_err[d];
      if (!r)          e.ctl[d] = 6'b001010;
      else if (p == 1) e.ctl[d] = 6'b000000;
      else if (p == 2) e.ctl[d] = 6'b000110;
      else if (p == 3) e.ctl[d] = {1'b1, 1'b1, !ds[d], 1'b1, 1'b0, 1'b1};
      else             e.ctl[d] = 6'b110100;
    end
    q.push_back(e);
    if (r) begin
      for (int d = 0; d < 2; d++) begin
        m_st[d] = (p == 1) ? 2 : (p == 2) ? 1 : (p == 3) ? 3 : 0;
        if (p <= 2) begin
          if (m_run[d] + 1 == MAXS + 1) m_err[d] = 1'b1;
          if (m_run[d] < MAXS + 1) m_run[d]++;
        end else begin
          m_run[d] = 0;
        end
        if (p == 2 && m_bc[d] < bcmax[d]) m_bc[d]++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 3'b000, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int d = 0; d < 2; d++) begin
        chk("ctl", d, 32'({pcwr[d], ifidwr[d], ififl[d],
                           idexwr[d], idexfl[d], redir[d]}), 32'(e.ctl[d]));
        chk("state", d, 32'(st[d]), 32'(e.st[d]));
        chk("stallerr", d, 32'(serr[d]), 32'(e.err[d]));
      end
      chk("bubblecnt", 0, 32'(bc0), 32'(e.bc[0]));
      chk("bubblecnt", 1, 32'(bc1), 32'(e.bc[1]));
    end
  end

  initial begin
    bit rm;
    step(0, 0, 0, 0, 3'b000, 0, 0);
    idle(2);
    // reset in the middle of a freeze, then release
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 3'b000, 0, 0);
    step(0, 0, 0, 1, 3'b000, 0, 0);
    idle(2);
    // single load-use bubble
    step(1, 0, 1, 0, 3'b000, 0, 0);
    idle(2);
    // two branch-operand bubbles then taken BEQ
    step(1, 1, 0, 0, 3'b001, 1, 0);
    step(1, 1, 0, 0, 3'b001, 1, 0);
    step(1, 0, 0, 0, 3'b001, 1, 0);
    idle(2);
    // freeze beats bubble
    for (int i = 0; i < 5; i++) step(1, 0, 1, 1, 3'b000, 0, 0);
    idle(2);
    // watchdog: nine busy cycles, then sticky error
    for (int i = 0; i < 9; i++) step(1, 0, 0, 1, 3'b000, 0, 0);
    idle(3);
    step(0, 0, 0, 0, 3'b000, 0, 0);
    idle(1);
    // bubble counter saturation and a jump
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 3'b000, 0, 0);
    step(1, 0, 0, 0, 3'b000, 0, 1);
    step(1, 0, 0, 0, 3'b000, 1, 0);
    idle(2);
    // randomized traffic with long busy runs and rare resets
    rm = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) rm = !rm;
      step($urandom_range(0, 299) != 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0,
           rm,
           $urandom_range(0, 1) ? 3'($urandom_range(1, 6)) : 3'b000,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 9) == 0);
    end
    idle(1);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain queue left %0d expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
